// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one registered WIDTH-bit adder between NREQ requesters
// with round-robin arbitration. One transaction is in flight at a time:
//   IDLE -> accept winner (operands latched) -> ADD (sum registered) -> RESP
//   (held until io_resp_ready) -> IDLE.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   io_req_valid     [NREQ]        per-requester operand valid
//   io_req_ready     [NREQ]        one-hot accept (combinational in IDLE)
//   io_req_a/b       [NREQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//   io_resp_valid    result available (RESP state)
//   io_resp_ready    consumer accepts result
//   io_resp_id       [IDW]   requester owning the result
//   io_resp_sum      [WIDTH] a+b mod 2^WIDTH
//   io_resp_carry    carry out of a+b (only with ADDER_ARB_CARRY_EN defined)
//
// Build option: define ADDER_ARB_CARRY_EN to widen the adder register by one
// bit and expose the carry on io_resp_carry.
module adder_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       io_req_valid,
  output logic [NREQ-1:0]       io_req_ready,
  input  logic [NREQ*WIDTH-1:0] io_req_a,
  input  logic [NREQ*WIDTH-1:0] io_req_b,
  output logic                  io_resp_valid,
  input  logic                  io_resp_ready,
  output logic [IDW-1:0]        io_resp_id,
  output logic [WIDTH-1:0]      io_resp_sum
`ifdef ADDER_ARB_CARRY_EN
  ,
  output logic                  io_resp_carry
`endif
);

`ifdef ADDER_ARB_CARRY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [IDW-1:0]        id_q, id_d;
  logic [IDW-1:0]        resp_id_q, resp_id_d;
  logic [WIDTH-1:0]      op_a_q, op_a_d;
  logic [WIDTH-1:0]      op_b_q, op_b_d;
  logic [SW-1:0]         sum_q, sum_d;

  // Unpacked view of the flat operand buses, one lane per requester.
  logic [NREQ-1:0][WIDTH-1:0] req_a, req_b;
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    assign req_a[i] = io_req_a[i*WIDTH +: WIDTH];
    assign req_b[i] = io_req_b[i*WIDTH +: WIDTH];
  end

  // Rotating search starting at ptr; first valid hit wins.
  logic           found;
  logic [IDW-1:0] win;
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && io_req_valid[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // Gated by rst_n so no grant is advertised while reset is held.
  assign io_req_ready = (rst_n && state_q == IDLE && found) ? (NREQ'(1) << win) : '0;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    resp_id_d = resp_id_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sum_d     = sum_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          op_a_d  = req_a[win];
          op_b_d  = req_b[win];
          id_d    = win;
          ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        // Response id moves together with the sum so both hold their last
        // value while the next transaction is being accepted.
        sum_d     = SW'(op_a_q) + SW'(op_b_q);
        resp_id_d = id_q;
        state_d   = RESP;
      end
      RESP: begin
        if (io_resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      id_q      <= '0;
      resp_id_q <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      resp_id_q <= resp_id_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      sum_q     <= sum_d;
    end
  end

  assign io_resp_valid = (state_q == RESP);
  assign io_resp_id    = resp_id_q;
  assign io_resp_sum   = sum_q[WIDTH-1:0];
`ifdef ADDER_ARB_CARRY_EN
  assign io_resp_carry = sum_q[WIDTH];
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
module tb_adder_arbiter;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   valid = '0;
  logic [N-1:0]   io_req_ready;
  logic [N*W-1:0] a_bus = '0;
  logic [N*W-1:0] b_bus = '0;
  logic           io_resp_valid;
  logic           resp_ready = 1'b1;
  logic [IW-1:0]  io_resp_id;
  logic [W-1:0]   io_resp_sum;
`ifdef ADDER_ARB_CARRY_EN
  logic           io_resp_carry;
`endif

  adder_arbiter #(.WIDTH(W), .NREQ(N), .IDW(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .io_req_valid(valid), .io_req_ready(io_req_ready),
    .io_req_a(a_bus), .io_req_b(b_bus),
    .io_resp_valid(io_resp_valid), .io_resp_ready(resp_ready),
    .io_resp_id(io_resp_id), .io_resp_sum(io_resp_sum)
`ifdef ADDER_ARB_CARRY_EN
    , .io_resp_carry(io_resp_carry)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one transaction in flight, age counts edges since accept.
  bit           m_busy;
  int           m_age;
  int           m_ptr;
  logic [W-1:0] m_sum, m_out_sum;
  int           m_id, m_out_id;
  logic         m_c, m_out_c;
  logic [N-1:0] last_er;
  int           done_ids[$];
  logic [W-1:0] done_sums[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    if (!rst_n || m_busy) return '0;
    for (int k = 0; k < N; k++) begin
      int idx = (m_ptr + k) % N;
      if (valid[idx]) return N'(1) << idx;
    end
    return '0;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_ptr = 0;
    m_sum = '0; m_out_sum = '0; m_id = 0; m_out_id = 0;
    m_c = 1'b0; m_out_c = 1'b0; last_er = '0;
  endtask

  // Called at posedge+1 after inputs are driven; checks, crosses one edge,
  // then advances the model.
  task automatic cycle();
    logic [N-1:0] er;
    logic [W:0]   s;
    int           w;
    bit           rr;
    #1;
    er = exp_ready();
    chk("req_ready",  32'(io_req_ready),  32'(er));
    chk("resp_valid", 32'(io_resp_valid), 32'(m_busy && m_age >= 1));
    chk("resp_sum",   32'(io_resp_sum),   32'(m_out_sum));
    chk("resp_id",    32'(io_resp_id),    32'(m_out_id));
`ifdef ADDER_ARB_CARRY_EN
    chk("resp_carry", 32'(io_resp_carry), 32'(m_out_c));
`endif
    last_er = er;
    w = 0;
    for (int i = 0; i < N; i++) if (er[i]) w = i;
    s  = {1'b0, a_bus[w*W +: W]} + {1'b0, b_bus[w*W +: W]};
    rr = resp_ready;
    @(posedge clk); #1;
    if (m_busy) begin
      if (m_age == 0) begin
        m_age = 1; m_out_sum = m_sum; m_out_id = m_id; m_out_c = m_c;
      end else if (rr) begin
        m_busy = 0;
        done_ids.push_back(m_out_id);
        done_sums.push_back(m_out_sum);
      end
    end else if (er != '0) begin
      m_busy = 1; m_age = 0;
      m_sum = s[W-1:0]; m_c = s[W]; m_id = w;
      m_ptr = (w + 1) % N;
    end
  endtask

  task automatic set_req(int i, logic v, logic [W-1:0] a, logic [W-1:0] b);
    valid[i] = v;
    a_bus[i*W +: W] = a;
    b_bus[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(io_req_ready), 32'(0));
    chk("rst_valid", 32'(io_resp_valid), 32'(0));
    chk("rst_sum",   32'(io_resp_sum), 32'(0));
    chk("rst_id",    32'(io_resp_id), 32'(0));
    rst_n = 1'b1;

    // Single request: req0 3+7
    set_req(0, 1'b1, 16'd3, 16'd7);
    #1 chk("t1_ready_same_cycle", 32'(io_req_ready), 32'(4'b0001));
    cycle();
    valid = '0;
    cycle();
    #1;
    chk("t1_valid", 32'(io_resp_valid), 32'(1));
    chk("t1_sum",   32'(io_resp_sum), 32'(10));
    chk("t1_id",    32'(io_resp_id), 32'(0));
    cycle();

    // Round-robin with all four held
    do_reset();
    done_ids.delete(); done_sums.delete();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, W'(i), W'(10 * i));
    resp_ready = 1'b1;
    repeat (15) cycle();
    valid = '0;
    chk("rr_count", 32'(done_ids.size()), 32'(5));
    for (int k = 0; k < 5 && k < done_ids.size(); k++) begin
      chk("rr_id",  32'(done_ids[k]),  32'(k % N));
      chk("rr_sum", 32'(done_sums[k]), 32'((k % N) * 11));
    end
    repeat (3) cycle();

    // Wrap / carry
    set_req(1, 1'b1, 16'hFFFF, 16'h0002);
    cycle();
    valid = '0;
    cycle();
    #1;
    chk("wrap_sum", 32'(io_resp_sum), 32'(16'h0001));
`ifdef ADDER_ARB_CARRY_EN
    chk("wrap_carry", 32'(io_resp_carry), 32'(1));
`endif
    cycle();

    // Backpressure on req2 21+8 while req0 waits
    set_req(2, 1'b1, 16'd21, 16'd8);
    cycle();
    valid = '0;
    set_req(0, 1'b1, 16'd100, 16'd1);
    resp_ready = 1'b0;
    cycle();
    repeat (5) begin
      #1;
      chk("bp_valid", 32'(io_resp_valid), 32'(1));
      chk("bp_sum",   32'(io_resp_sum), 32'(29));
      chk("bp_id",    32'(io_resp_id), 32'(2));
      cycle();
    end
    resp_ready = 1'b1;
    cycle();
    #1 chk("bp_ready_after", 32'(io_req_ready), 32'(4'b0001));
    cycle();
    valid = '0;
    repeat (3) cycle();

    // Pointer fairness
    do_reset();
    set_req(3, 1'b1, 16'd1, 16'd1);
    cycle();
    set_req(1, 1'b1, 16'd2, 16'd2);
    set_req(3, 1'b1, 16'd3, 16'd3);
    cycle();
    cycle();
    #1 chk("fair_grant1", 32'(io_req_ready), 32'(4'b0010));
    cycle();
    valid[1] = 1'b0;
    cycle();
    cycle();
    #1 chk("fair_grant3", 32'(io_req_ready), 32'(4'b1000));
    cycle();
    valid = '0;
    repeat (3) cycle();

    // Reset during ADD
    set_req(0, 1'b1, 16'd4, 16'd7);
    cycle();
    set_req(2, 1'b1, 16'd5, 16'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(io_req_ready), 32'(0));
    chk("mid_rst_valid", 32'(io_resp_valid), 32'(0));
    chk("mid_rst_sum",   32'(io_resp_sum), 32'(0));
    chk("mid_rst_id",    32'(io_resp_id), 32'(0));
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    valid = '0;
    repeat (4) cycle();
    set_req(1, 1'b1, 16'd9, 16'd9);
    set_req(2, 1'b1, 16'd5, 16'd5);
    #1 chk("mid_rst_from0", 32'(io_req_ready), 32'(4'b0010));
    cycle();
    valid[1] = 1'b0;
    repeat (6) cycle();
    valid = '0;
    repeat (3) cycle();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (last_er[i] || !valid[i]) begin
          if ($urandom_range(0, 1) == 1)
            set_req(i, 1'b1, W'($urandom), W'($urandom));
          else
            valid[i] = 1'b0;
        end else if ($urandom_range(0, 9) == 0) begin
          valid[i] = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    valid = '0;
    resp_ready = 1'b1;
    repeat (5) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one registered 16-bit adder between NREQ requesters, round-robin.
- Each requester offers an operand pair with a valid/ready handshake.
- Granted operands pass through the internal one-register adder. The sum is returned on a single response channel tagged with the requester id.
- Sits between the client blocks and the adder datapath; the adder itself is instantiated inside this block.

Parameters:
- WIDTH, 16, operand and sum width.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, response id width; must be ≥ clog2(NREQ).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- io_req_valid  input  NREQ  bit i: requester i has operands.
- io_req_ready  output  NREQ  bit i: requester i accepted this cycle (one-hot or zero).
- io_req_a  input  NREQ*WIDTH  operand A of requester i at bits [i*WIDTH +: WIDTH].
- io_req_b  input  NREQ*WIDTH  operand B, same packing.
- io_resp_valid  output  1  result available.
- io_resp_ready  input  1  consumer takes result.
- io_resp_id  output  IDW  index of the requester that owns the result.
- io_resp_sum  output  WIDTH  a+b mod 2^WIDTH.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr pointer=0.
  - io_req_ready=0, io_resp_valid=0, io_resp_id=0, io_resp_sum=0.
  - Operand registers cleared.
- States: IDLE, ADD, RESP.
- IDLE:
  - Search io_req_valid from index ptr upward, wrapping modulo NREQ. The first set bit is winner w.
  - io_req_ready = onehot(w), combinational from io_req_valid and ptr; 0 if no valid.
  - On the edge with a winner: latch a_w and b_w into the operand regs, latch id=w, set ptr=(w+1) mod NREQ, go to ADD.
- ADD:
  - The adder register captures opA+opB on this edge.
  - Go to RESP.
  - io_req_ready=0.
- RESP:
  - io_resp_valid=1; io_resp_sum and io_resp_id are stable.
  - Hold while io_resp_ready=0.
  - On an edge with io_resp_ready=1, go to IDLE; io_resp_valid deasserts next cycle.
  - io_req_ready=0.
- Latency: accept edge → io_resp_valid high 2 cycles later. Peak throughput is 1 result per 3 cycles.
- Arithmetic: WIDTH-bit wrap; carry is discarded (see optional feature).
- Requester rules:
  - A requester must hold valid, a and b stable until it sees ready.
  - Dropping valid before grant is legal and removes it from arbitration.
- Fairness: with all NREQ valid continuously, grant order is 0,1,2,3,0,…
- No starvation: any valid requester is granted within NREQ grants.
- Simultaneous valids are resolved solely by ptr; no fixed priority.
- io_resp_ready high outside RESP is ignored.
- Reset mid-operation: in-flight result is discarded, ptr returns to 0, no response emitted.
- Outputs io_resp_sum and io_resp_id retain their last value in IDLE/ADD. Only io_resp_valid qualifies them.

Optional Feature:
- Macro ADDER_ARB_CARRY_EN.
- Defined:
  - Extra port io_resp_carry, output, 1 bit = carry out of a+b.
  - Internal adder register is WIDTH+1 bits.
  - Carry is reset to 0 and valid with io_resp_valid.
- Undefined: port absent, adder register WIDTH bits, carry discarded.

Test Plan:
- Reset then single request: req0 a=3 b=7 → ready[0] same cycle; 2 cycles later resp_valid=1, sum=10, id=0.
- Round-robin: all four valid (a=i, b=10·i) held, resp_ready=1 → ids 0,1,2,3,0 in order; sums 0,11,22,33; 3-cycle spacing.
- Backpressure: req2 a=21 b=8, resp_ready=0 for 5 cycles → resp_valid stays 1, sum=29 id=2 stable; no new ready until 1 cycle after resp_ready=1.
- Wrap/carry: a=16'hFFFF b=16'h0002 → sum=16'h0001; with ADDER_ARB_CARRY_EN carry=1, without it port absent.
- Pointer fairness: after grant to 3, requests 1 and 3 both valid → grant 1; next cycle in IDLE with 3 still valid → grant 3.
- Reset mid-op: assert rst_n=0 during ADD for request a=4 b=7 → all outputs 0 immediately, no resp after release, next grant searches from 0.
